// File: rtl/intt_sched_if.sv
// Bus bundle for intt_sched: requester handshake/data on one side,
// inverse-NTT pipeline control and frame-completion status on the other.
// The scheduler connects through the slave modport; whoever drives the
// requests and the pipeline out_en strobe uses the master modport.
interface intt_sched_if #(
    parameter int DATA_WIDTH    = 12,
    parameter int MUL_STAGE_CNT = 4
);
    localparam int ADDR_W = (MUL_STAGE_CNT - 1 > 1) ? $clog2(MUL_STAGE_CNT - 1) : 1;

    logic [1:0]              req;
    logic [1:0]              gnt;
    logic [2*DATA_WIDTH-1:0] src0_data;
    logic [2*DATA_WIDTH-1:0] src1_data;
    logic                    intt_in_en;
    logic [2*DATA_WIDTH-1:0] intt_in;
    logic                    intt_out_en;
    logic [ADDR_W-1:0]       fifo_addr;
    logic                    out_owner;
    logic                    out_last;
    logic [1:0]              done;
    logic                    err;

    modport master (
        output req, src0_data, src1_data, intt_out_en,
        input  gnt, intt_in_en, intt_in, fifo_addr, out_owner, out_last, done, err
    );

    modport slave (
        input  req, src0_data, src1_data, intt_out_en,
        output gnt, intt_in_en, intt_in, fifo_addr, out_owner, out_last, done, err
    );
endinterface

// File: rtl/intt_sched.sv
// intt_sched: round-robin frame scheduler in front of a shared inverse-NTT
// pipeline. Two requesters take turns streaming whole frames of
// 2^(NTT_STAGE_CNT-1) coefficient-pair beats into the pipeline; an owner FIFO
// remembers who owns each frame still inside the pipeline so the output side
// can flag the last beat and pulse done to the right requester.
// Optional build macro INTT_SCHED_PERF_EN adds saturating performance counters
// (perf_busy, perf_frames, perf_stall).
module intt_sched #(
    parameter int NTT_STAGE_CNT = 8,
    parameter int MUL_STAGE_CNT = 4,
    parameter int DATA_WIDTH    = 12,
    parameter int MAX_INFLIGHT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    intt_sched_if.slave bus
`ifdef INTT_SCHED_PERF_EN
    ,
    output logic [31:0] perf_busy,
    output logic [15:0] perf_frames,
    output logic [31:0] perf_stall
`endif
);

    localparam int BW = NTT_STAGE_CNT - 1;
    localparam int AW = (MUL_STAGE_CNT - 1 > 1) ? $clog2(MUL_STAGE_CNT - 1) : 1;
    localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int CW = $clog2(MAX_INFLIGHT) + 1;

    // Frames are a power of two long, so the final beat index is all ones.
    localparam logic [BW-1:0] LAST_BEAT = '1;
    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_INFLIGHT);
    localparam logic [AW-1:0] ADDR_LAST = AW'(MUL_STAGE_CNT - 2);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        STALL
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              gnt_q, gnt_d;
    logic [BW-1:0]           inBeat_q, inBeat_d;
    logic                    prevWinner_q, prevWinner_d;
    logic                    inEn_q;
    logic [2*DATA_WIDTH-1:0] inData_q;

    logic [BW-1:0]           outBeat_q;
    logic [CW-1:0]           inflight_q;
    logic [PW-1:0]           rdPtr_q;
    logic [PW-1:0]           wrPtr_q;
    logic                    ownerMem_q [2**PW];
    logic [AW-1:0]           addr_q;
    logic                    err_q;

    logic                    streaming;
    logic                    lastInBeat;
    logic                    fifoEmpty;
    logic                    outLast;
    logic                    ownerHead;
    logic                    slotFree;
    logic                    grantNow;
    logic                    winner;

    assign streaming  = (state_q == STREAM);
    assign lastInBeat = streaming && (inBeat_q == LAST_BEAT);
    // The in-flight count doubles as the owner FIFO occupancy.
    assign fifoEmpty  = (inflight_q == '0);
    assign outLast    = bus.intt_out_en && (outBeat_q == LAST_BEAT) && !fifoEmpty;
    assign ownerHead  = fifoEmpty ? 1'b0 : ownerMem_q[rdPtr_q];
    // A frame draining this very cycle frees its slot in time for a new grant,
    // so a stalled requester restarts on the cycle right after the done pulse.
    assign slotFree   = (inflight_q < MAX_CNT) || outLast;
    assign grantNow   = (!streaming || lastInBeat) && (bus.req != 2'b00) && slotFree;
    // With both requesting, skip the previous winner; otherwise take whoever asks.
    assign winner     = (&bus.req) ? ~prevWinner_q : bus.req[1];

    // Next-state decode: new grant, continue the current frame, stall or go idle.
    always_comb begin
        state_d      = IDLE;
        gnt_d        = 2'b00;
        inBeat_d     = '0;
        prevWinner_d = prevWinner_q;
        if (grantNow) begin
            state_d      = STREAM;
            gnt_d        = winner ? 2'b10 : 2'b01;
            prevWinner_d = winner;
        end else if (streaming && !lastInBeat) begin
            state_d  = STREAM;
            gnt_d    = gnt_q;
            inBeat_d = inBeat_q + 1'b1;
        end else if (bus.req != 2'b00) begin
            state_d = STALL;
        end
    end

    // Arbiter state machine with registered grant and registered input path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= 2'b00;
            inBeat_q     <= '0;
            prevWinner_q <= 1'b1;
            inEn_q       <= 1'b0;
            inData_q     <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            inBeat_q     <= inBeat_d;
            prevWinner_q <= prevWinner_d;
            inEn_q       <= streaming;
            inData_q     <= gnt_q[0] ? bus.src0_data :
                            gnt_q[1] ? bus.src1_data : '0;
        end
    end

    // Owner FIFO and in-flight count: push on grant, pop on the last output beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            for (int i = 0; i < 2**PW; i++) begin
                ownerMem_q[i] <= 1'b0;
            end
        end else begin
            if (grantNow) begin
                ownerMem_q[wrPtr_q] <= winner;
                wrPtr_q             <= wrPtr_q + 1'b1;
            end
            if (outLast) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({grantNow, outLast})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Output beat counter; wraps naturally at the frame length.
    always_ff @(posedge clk) begin
        if (rst) begin
            outBeat_q <= '0;
        end else if (bus.intt_out_en) begin
            outBeat_q <= outBeat_q + 1'b1;
        end
    end

    // Shared circular address for the multiplier delay RAMs.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else if (inEn_q || bus.intt_out_en) begin
            addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
        end
    end

    // Sticky error: the pipeline produced data nobody is waiting for.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.intt_out_en && fifoEmpty) begin
            err_q <= 1'b1;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.intt_in_en = inEn_q;
    assign bus.intt_in    = inData_q;
    assign bus.fifo_addr  = addr_q;
    assign bus.out_owner  = ownerHead;
    assign bus.out_last   = outLast;
    assign bus.done       = outLast ? (ownerHead ? 2'b10 : 2'b01) : 2'b00;
    assign bus.err        = err_q;

`ifdef INTT_SCHED_PERF_EN
    logic [31:0] perfBusy_q;
    logic [15:0] perfFrames_q;
    logic [31:0] perfStall_q;

    // Saturating activity, completed-frame and stall-cycle counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perfBusy_q   <= '0;
            perfFrames_q <= '0;
            perfStall_q  <= '0;
        end else begin
            if ((inEn_q || bus.intt_out_en) && (perfBusy_q != '1)) begin
                perfBusy_q <= perfBusy_q + 1'b1;
            end
            if (outLast && (perfFrames_q != '1)) begin
                perfFrames_q <= perfFrames_q + 1'b1;
            end
            if ((state_q == STALL) && (perfStall_q != '1)) begin
                perfStall_q <= perfStall_q + 1'b1;
            end
        end
    end

    assign perf_busy   = perfBusy_q;
    assign perf_frames = perfFrames_q;
    assign perf_stall  = perfStall_q;
`endif

endmodule

// File: tb/tb_intt_sched.sv
// Testbench for intt_sched: directed scenarios plus a randomized run, all
// checked every cycle against a frame-level model (owner queue, frame
// countdown, modular address) and pinned with hand-computed literals.
module tb_intt_sched;

    localparam int NTT_STAGE_CNT = 8;
    localparam int MUL_STAGE_CNT = 4;
    localparam int DATA_WIDTH    = 12;
    localparam int MAX_INFLIGHT  = 4;
    localparam int FRAME         = 1 << (NTT_STAGE_CNT - 1);
    localparam int ADEPTH        = MUL_STAGE_CNT - 1;
    localparam int DW2           = 2 * DATA_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    intt_sched_if #(.DATA_WIDTH(DATA_WIDTH), .MUL_STAGE_CNT(MUL_STAGE_CNT)) bus ();

`ifdef INTT_SCHED_PERF_EN
    logic [31:0] perfBusy;
    logic [15:0] perfFrames;
    logic [31:0] perfStall;
`endif

    intt_sched #(
        .NTT_STAGE_CNT(NTT_STAGE_CNT),
        .MUL_STAGE_CNT(MUL_STAGE_CNT),
        .DATA_WIDTH   (DATA_WIDTH),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef INTT_SCHED_PERF_EN
        ,
        .perf_busy  (perfBusy),
        .perf_frames(perfFrames),
        .perf_stall (perfStall)
`endif
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Frame-level reference model state.
    int           mGnt       = -1;
    int           mBeatsLeft = 0;
    int           mPrev      = 1;
    int           mOutCnt    = 0;
    int           mAddr      = 0;
    bit           mInEn      = 1'b0;
    logic [DW2-1:0] mInData  = '0;
    bit           mErr       = 1'b0;
    int           mQ[$];

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 1'b0;

    // Directed-test tallies, updated once per cycle by stepCycle.
    int cyc = 0;
    int gnt0Cyc, gnt1Cyc, inEnCyc, doneCnt, firstGntCyc, firstInEnCyc;
    int addrSeq[6];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs held during the
    // cycle that just ended.
    task automatic modelStep();
        bit drain, deciding, grant;
        int winner;
        if (rst) begin
            mGnt = -1; mBeatsLeft = 0; mPrev = 1; mOutCnt = 0; mAddr = 0;
            mInEn = 1'b0; mInData = '0; mErr = 1'b0; mQ.delete();
        end else begin
            drain    = bus.intt_out_en && (mOutCnt == FRAME - 1) && (mQ.size() > 0);
            deciding = (mGnt < 0) || (mBeatsLeft == 1);
            grant    = deciding && (bus.req != 2'b00) && ((mQ.size() < MAX_INFLIGHT) || drain);
            if (mInEn || bus.intt_out_en) mAddr = (mAddr + 1) % ADEPTH;
            if (bus.intt_out_en && mQ.size() == 0) mErr = 1'b1;
            mInEn = (mGnt >= 0);
            if (mGnt == 0) mInData = bus.src0_data;
            else if (mGnt == 1) mInData = bus.src1_data;
            if (bus.intt_out_en) mOutCnt = (mOutCnt + 1) % FRAME;
            if (drain) void'(mQ.pop_front());
            if (grant) begin
                winner     = (bus.req == 2'b11) ? (1 - mPrev) : ((bus.req == 2'b10) ? 1 : 0);
                mQ.push_back(winner);
                mPrev      = winner;
                mGnt       = winner;
                mBeatsLeft = FRAME;
            end else if (mGnt >= 0 && mBeatsLeft > 1) begin
                mBeatsLeft--;
            end else begin
                mGnt       = -1;
                mBeatsLeft = 0;
            end
        end
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic checkOutput();
        logic [1:0] expGnt, expDone;
        bit expLast;
        int expOwner;
        expGnt   = (mGnt < 0) ? 2'b00 : ((mGnt == 0) ? 2'b01 : 2'b10);
        expLast  = bus.intt_out_en && (mOutCnt == FRAME - 1) && (mQ.size() > 0);
        expOwner = (mQ.size() > 0) ? mQ[0] : 0;
        expDone  = !expLast ? 2'b00 : ((expOwner == 0) ? 2'b01 : 2'b10);
        checkVal("gnt",        32'(bus.gnt),        32'(expGnt));
        checkVal("intt_in_en", 32'(bus.intt_in_en), 32'(mInEn));
        if (mInEn) checkVal("intt_in", 32'(bus.intt_in), 32'(mInData));
        checkVal("fifo_addr",  32'(bus.fifo_addr),  32'(mAddr));
        checkVal("out_owner",  32'(bus.out_owner),  32'(expOwner));
        checkVal("out_last",   32'(bus.out_last),   32'(expLast));
        checkVal("done",       32'(bus.done),       32'(expDone));
        checkVal("err",        32'(bus.err),        32'(mErr));
    endtask

    // Compare process: check the DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (checkEn) checkOutput();
    end

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input logic [1:0] r, input bit oe, input bit rs);
        @(posedge clk);
        #1;
        modelStep();
        bus.req         = r;
        bus.intt_out_en = oe;
        rst             = rs;
        bus.src0_data   = DW2'($urandom);
        bus.src1_data   = DW2'($urandom);
    endtask

    task automatic resetTallies();
        gnt0Cyc = 0; gnt1Cyc = 0; inEnCyc = 0; doneCnt = 0;
        firstGntCyc = -1; firstInEnCyc = -1;
        for (int i = 0; i < 6; i++) addrSeq[i] = -1;
    endtask

    task automatic stepCycle(input logic [1:0] r, input bit oe, input bit rs);
        applyStimulus(r, oe, rs);
        @(negedge clk);
        cyc++;
        if (bus.gnt == 2'b01) gnt0Cyc++;
        if (bus.gnt == 2'b10) gnt1Cyc++;
        if (bus.gnt != 2'b00 && firstGntCyc < 0) firstGntCyc = cyc;
        if (bus.intt_in_en) begin
            if (firstInEnCyc < 0) firstInEnCyc = cyc;
            if (inEnCyc < 6) addrSeq[inEnCyc] = int'(bus.fifo_addr);
            inEnCyc++;
        end
        if (bus.done != 2'b00) doneCnt++;
    endtask

    task automatic doReset();
        stepCycle(2'b00, 1'b0, 1'b1);
        stepCycle(2'b00, 1'b0, 1'b0);
    endtask

    logic [1:0] g[0:600];
    int doneAt;
    int expSeq[6] = '{0, 1, 2, 0, 1, 2};
    logic [1:0] rq;
    bit oe;

    initial begin
        bus.req = 2'b00; bus.intt_out_en = 1'b0; bus.src0_data = '0; bus.src1_data = '0;
        rst = 1'b1;
        resetTallies();
        stepCycle(2'b00, 1'b0, 1'b1);
        checkEn = 1'b1;
        doReset();
        checkVal("rst_gnt",   32'(bus.gnt),        32'd0);
        checkVal("rst_in_en", 32'(bus.intt_in_en), 32'd0);
        checkVal("rst_addr",  32'(bus.fifo_addr),  32'd0);
        checkVal("rst_err",   32'(bus.err),        32'd0);

        // Single frame from requester 0.
        $display("[TB] single frame");
        resetTallies();
        stepCycle(2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 140; i++) stepCycle(2'b00, 1'b0, 1'b0);
        checkVal("single_gnt0_cycles", 32'(gnt0Cyc), 32'd128);
        checkVal("single_gnt1_cycles", 32'(gnt1Cyc), 32'd0);
        checkVal("single_in_en_cycles", 32'(inEnCyc), 32'd128);
        checkVal("single_in_lag", 32'(firstInEnCyc - firstGntCyc), 32'd1);
        for (int i = 0; i < 6; i++) checkVal("addr_seq", 32'(addrSeq[i]), 32'(expSeq[i]));
        checkVal("addr_after_in", 32'(bus.fifo_addr), 32'd2);
        doneAt = -1;
        for (int i = 0; i < FRAME; i++) begin
            stepCycle(2'b00, 1'b1, 1'b0);
            if (bus.done == 2'b01) doneAt = i;
        end
        stepCycle(2'b00, 1'b0, 1'b0);
        checkVal("single_done_beat", 32'(doneAt), 32'd127);
        checkVal("single_done_count", 32'(doneCnt), 32'd1);
        checkVal("addr_after_out", 32'(bus.fifo_addr), 32'd1);
        checkVal("single_err", 32'(bus.err), 32'd0);

        // Contention: both requesting, frames alternate with no gap.
        $display("[TB] contention");
        doReset();
        for (int i = 0; i < 400; i++) begin
            stepCycle(2'b11, 1'b0, 1'b0);
            g[i] = bus.gnt;
        end
        checkVal("cont_g0",   32'(g[0]),   32'b00);
        checkVal("cont_g1",   32'(g[1]),   32'b01);
        checkVal("cont_g128", 32'(g[128]), 32'b01);
        checkVal("cont_g129", 32'(g[129]), 32'b10);
        checkVal("cont_g256", 32'(g[256]), 32'b10);
        checkVal("cont_g257", 32'(g[257]), 32'b01);

        // Backpressure: four frames fill the pipeline, then stall until a drain.
        $display("[TB] backpressure");
        doReset();
        resetTallies();
        for (int i = 0; i < 4 * FRAME + 20; i++) begin
            stepCycle(2'b01, 1'b0, 1'b0);
            g[i] = bus.gnt;
        end
        checkVal("bp_gnt_cycles", 32'(gnt0Cyc), 32'd512);
        checkVal("bp_stall_gnt", 32'(g[520]), 32'b00);
        doneAt = -1;
        for (int i = 0; i < FRAME; i++) begin
            stepCycle(2'b01, 1'b1, 1'b0);
            if (bus.done != 2'b00) doneAt = i;
            if (i == FRAME - 1) checkVal("bp_gnt_at_done", 32'(bus.gnt), 32'b00);
        end
        checkVal("bp_done_beat", 32'(doneAt), 32'd127);
        stepCycle(2'b01, 1'b0, 1'b0);
        checkVal("bp_regrant", 32'(bus.gnt), 32'b01);

        // Error flag with nothing in flight, then cleared by reset.
        $display("[TB] error flag");
        doReset();
        stepCycle(2'b00, 1'b1, 1'b0);
        checkVal("err_same_cycle", 32'(bus.err), 32'd0);
        stepCycle(2'b00, 1'b0, 1'b0);
        checkVal("err_next_cycle", 32'(bus.err), 32'd1);
        for (int i = 0; i < 5; i++) stepCycle(2'b00, 1'b0, 1'b0);
        checkVal("err_sticky", 32'(bus.err), 32'd1);
        doReset();
        checkVal("err_cleared", 32'(bus.err), 32'd0);

        // Reset in the middle of a frame abandons it without a done pulse.
        $display("[TB] reset mid-frame");
        stepCycle(2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) stepCycle(2'b00, (i >= 10), 1'b0);
        stepCycle(2'b00, 1'b0, 1'b1);
        stepCycle(2'b00, 1'b0, 1'b0);
        checkVal("mid_rst_gnt",   32'(bus.gnt),        32'd0);
        checkVal("mid_rst_in_en", 32'(bus.intt_in_en), 32'd0);
        checkVal("mid_rst_in",    32'(bus.intt_in),    32'd0);
        checkVal("mid_rst_last",  32'(bus.out_last),   32'd0);
        checkVal("mid_rst_owner", 32'(bus.out_owner),  32'd0);
        checkVal("mid_rst_addr",  32'(bus.fifo_addr),  32'd0);
        resetTallies();
        for (int i = 0; i < 200; i++) stepCycle(2'b00, 1'b1, 1'b0);
        checkVal("mid_rst_no_done", 32'(doneCnt), 32'd0);

        // Randomized traffic against the model.
        $display("[TB] random traffic");
        doReset();
        rq = 2'b00;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) rq = 2'($urandom_range(0, 3));
            oe = ((mQ.size() >= 2) ||
                  (mQ.size() == 1 && !(bus.intt_out_en && mOutCnt == FRAME - 1))) &&
                 ($urandom_range(0, 3) != 0);
            stepCycle(rq, oe, 1'b0);
        end

`ifdef INTT_SCHED_PERF_EN
        // Performance counters after two complete frames.
        $display("[TB] perf counters");
        doReset();
        for (int f = 0; f < 2; f++) begin
            stepCycle(2'b01, 1'b0, 1'b0);
            for (int i = 0; i < 140; i++) stepCycle(2'b00, 1'b0, 1'b0);
            for (int i = 0; i < FRAME; i++) stepCycle(2'b00, 1'b1, 1'b0);
        end
        stepCycle(2'b00, 1'b0, 1'b0);
        checkVal("perf_frames", 32'(perfFrames), 32'd2);
        checkVal("perf_busy_min", 32'(perfBusy >= 32'd256), 32'd1);
`endif

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
